// File: rtl/shift_left_pkg.sv
// Shared helpers for the shift_left barrel shifter: derived widths and default size.
package shift_left_pkg;

    localparam int DEF_DIW = 32'd4;

    function automatic int sl_sw(input int diw);
        return $clog2(diw);
    endfunction

    function automatic int sl_dow(input int diw);
        return (32'd2 * diw) - 32'd1;
    endfunction

endpackage

// File: rtl/shift_left_stage.sv
// One barrel-shifter stage: shifts left by the fixed amount SH when enabled, else passes through.
module shift_left_stage #(
    parameter int W  = 32'd7,
    parameter int SH = 32'd1
) (
    input  logic         en_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o
);

    // Conditional fixed shift.
    always_comb begin
        if (en_i) begin
            data_o = data_i << SH;
        end else begin
            data_o = data_i;
        end
    end

endmodule

// File: rtl/shift_left.sv
// Registered logical left barrel shifter with valid qualifier.
// Define SHIFT_LEFT_PIPE_EN to cut the stage chain with an extra register (latency 2).
module shift_left
    import shift_left_pkg::*;
#(
    parameter int DIW = DEF_DIW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DIW-1:0]           a,
    input  logic [sl_sw(DIW)-1:0]    n,
    output logic                     out_valid,
    output logic [sl_dow(DIW)-1:0]   y
);

    localparam int SW  = sl_sw(DIW);
    localparam int DOW = sl_dow(DIW);
    localparam int CUT = SW / 32'd2;
    localparam logic [SW:0] DIW_C = (SW+1)'(DIW);

    logic [DOW-1:0] base_s;
    logic [DOW-1:0] st_s [SW];
    logic [DOW-1:0] res_s;
    logic           res_v_s;
    logic [DOW-1:0] y_d;
    logic [DOW-1:0] y_q;
    logic           out_valid_q;

    // Out-of-range amounts are zeroed at the source so every later stage sees a zero operand.
    always_comb begin
        if ({1'b0, n} < DIW_C) begin
            base_s = {{(DOW-DIW){1'b0}}, a};
        end else begin
            base_s = {DOW{1'b0}};
        end
    end

`ifdef SHIFT_LEFT_PIPE_EN
    logic [DOW-1:0] mid_d;
    logic [DOW-1:0] mid_q;
    logic [SW-1:0]  n_mid_d;
    logic [SW-1:0]  n_mid_q;
    logic           mid_v_q;

    // Mid-pipeline capture; data and remaining shift bits hold while idle.
    always_comb begin
        if (in_valid) begin
            mid_d   = st_s[CUT];
            n_mid_d = n;
        end else begin
            mid_d   = mid_q;
            n_mid_d = n_mid_q;
        end
    end

    // Mid-pipeline registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mid_q   <= {DOW{1'b0}};
            n_mid_q <= {SW{1'b0}};
            mid_v_q <= 1'b0;
        end else begin
            mid_q   <= mid_d;
            n_mid_q <= n_mid_d;
            mid_v_q <= in_valid;
        end
    end
`endif

    for (genvar k = 0; k < SW; k++) begin : g_stage
        logic [DOW-1:0] in_s;
        logic           en_s;
        if (k == 0) begin : g_first
            assign in_s = base_s;
            assign en_s = n[0];
`ifdef SHIFT_LEFT_PIPE_EN
        end else if (k == CUT + 1) begin : g_cut
            assign in_s = mid_q;
            assign en_s = n_mid_q[k];
        end else if (k > CUT + 1) begin : g_late
            assign in_s = st_s[k-1];
            assign en_s = n_mid_q[k];
`endif
        end else begin : g_early
            assign in_s = st_s[k-1];
            assign en_s = n[k];
        end

        shift_left_stage #(
            .W  (DOW),
            .SH (1 << k)
        ) u_stage (
            .en_i   (en_s),
            .data_i (in_s),
            .data_o (st_s[k])
        );
    end

`ifdef SHIFT_LEFT_PIPE_EN
    if (CUT == SW - 1) begin : g_res_mid
        assign res_s = mid_q;
    end else begin : g_res_last
        assign res_s = st_s[SW-1];
    end
    assign res_v_s = mid_v_q;
`else
    assign res_s   = st_s[SW-1];
    assign res_v_s = in_valid;
`endif

    // Output holds its last result through idle cycles.
    always_comb begin
        if (res_v_s) begin
            y_d = res_s;
        end else begin
            y_d = y_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q         <= {DOW{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            y_q         <= y_d;
            out_valid_q <= res_v_s;
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_shift_left.sv
// Self-checking bench for shift_left: DIW=4 and DIW=5 instances against a queue-based reference.
module tb_shift_left;

`ifdef SHIFT_LEFT_PIPE_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [1:0] n;
    logic       out_valid;
    logic [6:0] y;
    logic       in_valid5;
    logic [4:0] a5;
    logic [2:0] n5;
    logic       out_valid5;
    logic [8:0] y5;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    shift_left #(.DIW(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .n(n),
        .out_valid(out_valid), .y(y)
    );

    shift_left #(.DIW(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .a(a5), .n(n5),
        .out_valid(out_valid5), .y(y5)
    );

    function automatic int ref_shl(int diw, int av, int nv);
        if (nv >= diw) return 0;
        return av * (1 << nv);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each accepted operation emerges L edges later; idle slots leave y unchanged.
    typedef struct { bit v; int y; } ent_t;
    ent_t q4[$];
    ent_t q5[$];
    bit   ev4 = 1'b0, ev5 = 1'b0;
    int   ey4 = 0, ey5 = 0;

    always @(posedge clk) begin
        ent_t e;
        if (!rst_n) begin
            q4.delete();
            q5.delete();
            for (int i = 0; i < L - 1; i++) begin
                q4.push_back('{v: 1'b0, y: 0});
                q5.push_back('{v: 1'b0, y: 0});
            end
            ev4 = 1'b0; ey4 = 0;
            ev5 = 1'b0; ey5 = 0;
        end else begin
            q4.push_back('{v: in_valid, y: (in_valid ? ref_shl(4, a, n) : 0)});
            e = q4.pop_front();
            ev4 = e.v;
            if (e.v) ey4 = e.y;
            q5.push_back('{v: in_valid5, y: (in_valid5 ? ref_shl(5, a5, n5) : 0)});
            e = q5.pop_front();
            ev5 = e.v;
            if (e.v) ey5 = e.y;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", out_valid, ev4);
            check("y", y, ey4);
            check("out_valid5", out_valid5, ev5);
            check("y5", y5, ey5);
        end
    end

    int ca[4] = '{1, 1, 15, 15};
    int cn[4] = '{0, 3, 3, 0};
    int ce[4] = '{1, 8, 120, 15};
    int bv[3] = '{1, 0, 0};
    int ba[3] = '{5, 9, 9};
    int bn[3] = '{2, 1, 1};
    int bo[3] = '{1, 0, 0};
    int pn[3] = '{4, 5, 7};
    int pe[3] = '{496, 0, 0};

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; a = 4'd15; n = 2'd3;
        in_valid5 = 1'b0; a5 = 5'd0; n5 = 3'd0;
        @(posedge clk);
        chk_en = 1'b1;

        // Reset held with a valid operand presented.
        repeat (3) begin
            @(negedge clk);
            check("rst_y", y, 0);
            check("rst_valid", out_valid, 0);
        end
        rst_n = 1'b1;
        for (int c = 1; c <= L; c++) begin
            @(negedge clk);
            check("first_valid", out_valid, (c == L) ? 1 : 0);
            check("first_y", y, (c == L) ? 120 : 0);
        end

        // Corners back to back.
        for (int c = 0; c < 4 + L; c++) begin
            @(negedge clk);
            if (c < 4) begin
                in_valid = 1'b1; a = ca[c][3:0]; n = cn[c][1:0];
            end else begin
                in_valid = 1'b0;
            end
            if (c >= L) begin
                check("corner_y", y, ce[c-L]);
                check("corner_valid", out_valid, 1);
            end
        end

        // Exhaustive sweep, one per cycle.
        for (int av = 1; av < 16; av++) begin
            for (int nv = 0; nv < 4; nv++) begin
                @(negedge clk);
                in_valid = 1'b1; a = av[3:0]; n = nv[1:0];
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (L) @(negedge clk);

        // Bubble: one valid then two idles with different operand values.
        for (int c = 0; c < 3 + L; c++) begin
            @(negedge clk);
            if (c < 3) begin
                in_valid = bv[c][0]; a = ba[c][3:0]; n = bn[c][1:0];
            end else begin
                in_valid = 1'b0;
            end
            if (c >= L) begin
                check("bubble_y", y, 20);
                check("bubble_valid", out_valid, bo[c-L]);
            end
        end

        // Reset hits while 7<<2 is in flight.
        @(negedge clk);
        in_valid = 1'b1; a = 4'd7; n = 2'd2;
        rst_n = (L == 1) ? 1'b0 : 1'b1;
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check("midrst_y", y, 0);
        check("midrst_valid", out_valid, 0);
        rst_n = 1'b1;
        repeat (L + 1) begin
            @(negedge clk);
            check("midrst_no28", (y == 7'd28) ? 1 : 0, 0);
        end

        // Wider instance, including out-of-range shift amounts.
        for (int c = 0; c < 3 + L; c++) begin
            @(negedge clk);
            if (c < 3) begin
                in_valid5 = 1'b1; a5 = 5'd31; n5 = pn[c][2:0];
            end else begin
                in_valid5 = 1'b0;
            end
            if (c >= L) begin
                check("diw5_y", y5, pe[c-L]);
                check("diw5_valid", out_valid5, 1);
            end
        end

        // Randomised traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rst_n     = ($urandom_range(0, 49) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = 4'($urandom);
            n         = 2'($urandom);
            in_valid5 = ($urandom_range(0, 3) != 0);
            a5        = 5'($urandom);
            n5        = 3'($urandom);
        end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; in_valid5 = 1'b0;
        repeat (L + 1) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_left.md
Name: shift_left

Overview:
- Registered logical left shifter (barrel shifter) with a valid qualifier.
- Takes an unsigned DIW-bit operand `a` and a shift amount `n` in 0..DIW-1.
- Produces `y = a << n` zero-extended into a (2*DIW-1)-bit result, so no bit is ever lost.
- Used as a datapath primitive for scaling and normalisation.

Parameters:
- DIW, 4, input data width (>=2).
- SW, $clog2(DIW), shift-amount width; derived, not overridden.
- DOW, 2*DIW-1, output width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  `a`/`n` valid this cycle.
- a  input  DIW  unsigned operand.
- n  input  SW  shift amount, 0..DIW-1 meaningful.
- out_valid  output  1  `y` valid.
- y  output  DOW  shifted result.

Behaviour:
- One clock and one reset; reset is synchronous and active-low (`rst_n` sampled on the `clk` rising edge).
- While `rst_n`=0 at an edge: `y`<=0 and `out_valid`<=0. Any in-flight operation is discarded, including one accepted in the same cycle reset asserts.
- Function: `y = {{(DOW-DIW){1'b0}}, a} << n`, a logical shift with zero fill from the LSB.
  - Max result is (2^DIW-1)<<(DIW-1), which fits in DOW bits exactly; no overflow is possible.
- If `n` >= DIW (only possible when DIW is not a power of 2), `y`=0.
- Structure: log2 barrel shifter of SW stages. Stage k shifts by 2^k when `n[k]`=1, else passes through. Each stage is DOW bits wide.
- Latency: 1 cycle (default build).
  - An input sampled with `in_valid`=1 at edge t appears on `y` with `out_valid`=1 after edge t.
  - `in_valid`=0 at edge t gives `out_valid`=0 after edge t; `y` holds its previous value (no update).
- No backpressure: one result per cycle at full throughput; back-to-back inputs are never dropped.
- `a`=0 gives `y`=0 for any `n`.
- `n`=0 gives `y` = zero-extended `a`.
- Outputs are driven only from registers; no combinational path from inputs to outputs.

Optional Feature:
- Macro SHIFT_LEFT_PIPE_EN.
- Defined:
  - A pipeline register is inserted after stage floor(SW/2) of the barrel shifter, together with the matching valid bit.
  - Latency becomes 2 cycles; throughput is still 1 per cycle.
  - Reset clears both pipeline valids and both data registers to 0.
  - When SW=1, the extra register sits after the single stage, and the output register still follows it.
- Not defined: single-register implementation, latency 1 as above.
- Functional results are identical in both builds; only latency differs.

Decomposition:
- Package `shift_left_pkg`:
  - Function `sl_sw(diw)` returning $clog2(diw).
  - Function `sl_dow(diw)` returning 2*diw-1.
  - Localparam DEF_DIW=4.
- Sub-module `shift_left_stage`:
  - Parameters W and SH.
  - Combinational: `out = en ? (in << SH) : in`.
  - The top instantiates one per shift bit in a generate loop.

Test Plan (DIW=4, SW=2, DOW=7; latency L=1, or 2 with SHIFT_LEFT_PIPE_EN):
- Reset: hold `rst_n`=0 for 3 cycles with `in_valid`=1, `a`=15, `n`=3 -> `y`=0 and `out_valid`=0 throughout. First result is valid L cycles after release.
- Corners:
  - `a`=1, `n`=0 -> `y`=1.
  - `a`=1, `n`=3 -> `y`=8.
  - `a`=15, `n`=3 -> `y`=120 (7'h78).
  - `a`=15, `n`=0 -> `y`=15.
- Exhaustive sweep: `a`=1..15, `n`=0..3 back-to-back, one per cycle with `in_valid`=1 -> each `y` equals `a`<<`n` exactly L cycles later, and `out_valid` stays 1 continuously.
- Bubble: `a`=5, `n`=2 valid, then 2 idle cycles with `a`=9, `n`=1 -> `y`=20 with `out_valid`=1, then `out_valid`=0 with `y` held at 20.
- Reset mid-stream: assert `rst_n`=0 one cycle after issuing `a`=7, `n`=2 -> result 28 never appears and `y`=0.
- Parameter sweep: DIW=5 (SW=3, DOW=9), `a`=31, `n`=4 -> `y`=496; `n`=5 -> `y`=0 (out-of-range rule).
